// File: rtl/camo_bist_ctrl.sv
// BIST controller for the camouflaged core: clears it, applies a counting vector
// sequence, folds {Q1,Q2,Q3} into a 16-bit MISR and compares against a golden value.
module camo_bist_ctrl #(
  parameter int          N_VEC      = 16,
  parameter int          SETTLE     = 2,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  output logic [3:0]  vec_o,
  output logic        core_rst,
  input  logic [2:0]  q_i,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_APPLY,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [7:0]  LAST_IDX    = 8'(N_VEC - 1);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [15:0] SIG_SEED    = 16'hFFFF;

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] sig_q, sig_d;
  logic        pass_q, pass_d;
  logic [3:0]  vec_q, vec_d;
  logic        core_rst_q, core_rst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        drive_vec;

  function automatic logic [15:0] misr_fold(input logic [15:0] s, input logic [2:0] q);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {13'b0, q};
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          cnt_d   = '0;
          sig_d   = SIG_SEED;
          pass_d  = 1'b0;
        end
      end
      S_CLR: begin
        if (cnt_q == 4'd1) begin
          state_d = S_APPLY;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_APPLY: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CAPTURE: begin
        sig_d = misr_fold(sig_q, q_i);
        idx_d = idx_q + 8'd1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          pass_d  = (sig_d == GOLDEN_SIG);
        end else begin
          state_d = S_APPLY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so every port comes straight off a flop.
    drive_vec  = (state_d == S_APPLY) || (state_d == S_CAPTURE);
    vec_d      = drive_vec ? idx_d[3:0] : 4'h0;
    core_rst_d = !drive_vec;
    busy_d     = drive_vec || (state_d == S_CLR);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      sig_q      <= SIG_SEED;
      pass_q     <= 1'b0;
      vec_q      <= 4'h0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      sig_q      <= sig_d;
      pass_q     <= pass_d;
      vec_q      <= vec_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign vec_o     = vec_q;
  assign core_rst  = core_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_camo_bist_ctrl.sv
// Self-checking bench for camo_bist_ctrl: four configurations, a small stand-in core
// with sequential state, and a signature model built from the vector/capture rules.
module tb_camo_bist_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  localparam int S3 = 2;

  // N_VEC=1, SETTLE=1, golden matches the all-zero capture
  logic        start1 = 1'b0;
  logic [2:0]  q1 = 3'b000;
  logic [3:0]  vec1;
  logic        crst1, busy1, done1, pass1;
  logic [15:0] sig1;
  camo_bist_ctrl #(.N_VEC(1), .SETTLE(1), .GOLDEN_SIG(16'hEFDF)) u1 (
    .CLK(CLK), .RST(RST), .start(start1), .vec_o(vec1), .core_rst(crst1), .q_i(q1),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1));

  // N_VEC=2, SETTLE=1
  logic        start2 = 1'b0;
  logic [2:0]  q2 = 3'b000;
  logic [3:0]  vec2;
  logic        crst2, busy2, done2, pass2;
  logic [15:0] sig2;
  camo_bist_ctrl #(.N_VEC(2), .SETTLE(1), .GOLDEN_SIG(16'h0000)) u2 (
    .CLK(CLK), .RST(RST), .start(start2), .vec_o(vec2), .core_rst(crst2), .q_i(q2),
    .busy(busy2), .done(done2), .pass(pass2), .signature(sig2));

  // N_VEC=20, SETTLE=2, with a stand-in core
  logic        start3 = 1'b0;
  logic [2:0]  q3;
  logic [3:0]  vec3;
  logic        crst3, busy3, done3, pass3;
  logic [15:0] sig3;
  camo_bist_ctrl #(.N_VEC(20), .SETTLE(S3), .GOLDEN_SIG(16'h0000)) u3 (
    .CLK(CLK), .RST(RST), .start(start3), .vec_o(vec3), .core_rst(crst3), .q_i(q3),
    .busy(busy3), .done(done3), .pass(pass3), .signature(sig3));

  // Stand-in core: registered lookup, inverted once vector 15 has been seen since clear.
  logic [2:0] tbl [16];
  logic [2:0] core_q;
  logic       lap;
  always_ff @(posedge CLK) begin
    if (crst3) begin
      core_q <= 3'b000;
      lap    <= 1'b0;
    end else begin
      core_q <= tbl[vec3] ^ {3{lap}};
      lap    <= lap | (vec3 == 4'hF);
    end
  end
  assign q3 = core_q;

  // N_VEC=16, SETTLE=2
  logic        start4 = 1'b0;
  logic [2:0]  q4 = 3'b000;
  logic [3:0]  vec4;
  logic        crst4, busy4, done4, pass4;
  logic [15:0] sig4;
  camo_bist_ctrl #(.N_VEC(16), .SETTLE(2), .GOLDEN_SIG(16'h0000)) u4 (
    .CLK(CLK), .RST(RST), .start(start4), .vec_o(vec4), .core_rst(crst4), .q_i(q4),
    .busy(busy4), .done(done4), .pass(pass4), .signature(sig4));

  function automatic logic [15:0] fold(input logic [15:0] s, input logic [2:0] q);
    logic [15:0] r;
    r = {s[14:0], 1'b0} ^ {13'b0, q};
    if (s[15]) r = r ^ 16'h1021;
    return r;
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    tests++; if (vec1 !== 4'h0) begin fails++; $display("FAIL reset_vec: got %h expected 0", vec1); end
    tests++; if (crst1 !== 1'b1) begin fails++; $display("FAIL reset_core_rst: got %b expected 1", crst1); end
    tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    tests++; if (done1 !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done1); end
    tests++; if (pass1 !== 1'b0) begin fails++; $display("FAIL reset_pass: got %b expected 0", pass1); end
    tests++; if (sig1 !== 16'hFFFF) begin fails++; $display("FAIL reset_sig: got %h expected ffff", sig1); end
    tests++;
    if ({vec4, crst4, busy4, done4, pass4, sig4} !== {4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF}) begin
      fails++; $display("FAIL reset_u4: got %h expected %h", {vec4, crst4, busy4, done4, pass4, sig4},
                        {4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF});
    end
    RST = 1'b0;
  endtask

  task automatic test_single_vector(input logic [2:0] qv, input logic [15:0] exp_sig, input logic exp_pass);
    int done_cyc;
    int n_done;
    done_cyc = -1;
    n_done   = 0;
    q1 = qv;
    @(negedge CLK); start1 = 1'b1;
    @(posedge CLK); #1 start1 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (done1 === 1'b1) begin n_done++; if (done_cyc < 0) done_cyc = c; end
      tests++; if (busy1 !== (c <= 4)) begin fails++; $display("FAIL single_busy c%0d: got %b expected %b", c, busy1, (c <= 4)); end
      tests++; if (crst1 !== !(c == 3 || c == 4)) begin fails++; $display("FAIL single_core_rst c%0d: got %b expected %b", c, crst1, !(c == 3 || c == 4)); end
      if (c == 1) begin
        tests++; if (sig1 !== 16'hFFFF || pass1 !== 1'b0) begin fails++; $display("FAIL single_start_clear: got sig %h pass %b expected ffff 0", sig1, pass1); end
      end
      if (c == 5 || c == 7) begin
        tests++; if (sig1 !== exp_sig) begin fails++; $display("FAIL single_sig c%0d: got %h expected %h", c, sig1, exp_sig); end
        tests++; if (pass1 !== exp_pass) begin fails++; $display("FAIL single_pass c%0d: got %b expected %b", c, pass1, exp_pass); end
      end
    end
    tests++; if (done_cyc != 5) begin fails++; $display("FAIL single_done_cycle: got %0d expected 5", done_cyc); end
    tests++; if (n_done != 1) begin fails++; $display("FAIL single_done_pulses: got %0d expected 1", n_done); end
  endtask

  task automatic test_two_vectors();
    int done_cyc;
    logic [3:0] exp_vec;
    done_cyc = -1;
    q2 = 3'b000;
    @(negedge CLK); start2 = 1'b1;
    @(posedge CLK); #1 start2 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (done2 === 1'b1 && done_cyc < 0) done_cyc = c;
      if (c >= 3 && c <= 6) begin
        exp_vec = 4'((c - 3) / 2);
        tests++; if (vec2 !== exp_vec) begin fails++; $display("FAIL two_vec c%0d: got %h expected %h", c, vec2, exp_vec); end
      end
      if (c == 7) begin
        tests++; if (sig2 !== 16'hCF9F) begin fails++; $display("FAIL two_sig: got %h expected cf9f", sig2); end
        tests++; if (pass2 !== 1'b0) begin fails++; $display("FAIL two_pass: got %b expected 0", pass2); end
        tests++; if (busy2 !== 1'b0) begin fails++; $display("FAIL two_busy_at_done: got %b expected 0", busy2); end
      end
    end
    tests++; if (done_cyc != 7) begin fails++; $display("FAIL two_done_cycle: got %0d expected 7", done_cyc); end
  endtask

  task automatic test_wrap_with_core();
    logic [15:0] exp_sig;
    logic [2:0]  qk;
    logic [3:0]  exp_vec;
    int done_cyc;
    int n_done;
    int vec_bad;
    foreach (tbl[i]) tbl[i] = 3'($urandom);
    // Vector k sees the core inverted once vector 15 has been applied for a full cycle before capture.
    exp_sig = 16'hFFFF;
    for (int k = 0; k < 20; k++) begin
      qk = tbl[k % 16];
      if (k >= 16 || (k == 15 && S3 >= 2)) qk = qk ^ 3'b111;
      exp_sig = fold(exp_sig, qk);
    end
    done_cyc = -1;
    n_done   = 0;
    vec_bad  = 0;
    @(negedge CLK); start3 = 1'b1;
    @(posedge CLK); #1 start3 = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge CLK);
      if (done3 === 1'b1) begin n_done++; if (done_cyc < 0) done_cyc = c; end
      if (c >= 3 && c <= 62) begin
        exp_vec = 4'(((c - 3) / (S3 + 1)) % 16);
        if (vec3 !== exp_vec) begin
          vec_bad++;
          $display("FAIL wrap_vec c%0d: got %h expected %h", c, vec3, exp_vec);
        end
      end
      if (c == 63) begin
        tests++; if (sig3 !== exp_sig) begin fails++; $display("FAIL wrap_sig: got %h expected %h", sig3, exp_sig); end
        tests++; if (pass3 !== (exp_sig == 16'h0000)) begin fails++; $display("FAIL wrap_pass: got %b expected %b", pass3, (exp_sig == 16'h0000)); end
      end
      if (c == 70) begin
        tests++; if (busy3 !== 1'b0) begin fails++; $display("FAIL wrap_no_restart: got busy %b expected 0", busy3); end
      end
      start3 = (c <= 58) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start3 = 1'b0;
    tests++; if (vec_bad != 0) begin fails++; $display("FAIL wrap_vec_total: got %0d bad expected 0", vec_bad); end
    tests++; if (done_cyc != 63) begin fails++; $display("FAIL wrap_done_cycle: got %0d expected 63", done_cyc); end
    tests++; if (n_done != 1) begin fails++; $display("FAIL wrap_done_pulses: got %0d expected 1", n_done); end
  endtask

  task automatic test_reset_mid_run();
    int n_done;
    n_done = 0;
    q4 = 3'($urandom);
    @(negedge CLK); start4 = 1'b1;
    @(posedge CLK); #1 start4 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (done4 === 1'b1) n_done++;
      if (c == 10) RST = 1'b1;
    end
    @(negedge CLK);
    tests++; if (busy4 !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy4); end
    tests++; if (crst4 !== 1'b1) begin fails++; $display("FAIL midrst_core_rst: got %b expected 1", crst4); end
    tests++; if (sig4 !== 16'hFFFF) begin fails++; $display("FAIL midrst_sig: got %h expected ffff", sig4); end
    tests++; if (vec4 !== 4'h0 || pass4 !== 1'b0) begin fails++; $display("FAIL midrst_vec_pass: got %h %b expected 0 0", vec4, pass4); end
    RST = 1'b0;
    repeat (60) begin
      @(negedge CLK);
      if (done4 === 1'b1) n_done++;
    end
    tests++; if (n_done != 0) begin fails++; $display("FAIL midrst_no_done: got %0d pulses expected 0", n_done); end
  endtask

  task automatic test_random_run();
    logic [2:0]  qv [16];
    logic [15:0] exp_sig;
    int done_cyc;
    int n_done;
    exp_sig = 16'hFFFF;
    for (int k = 0; k < 16; k++) begin
      qv[k]   = 3'($urandom);
      exp_sig = fold(exp_sig, qv[k]);
    end
    done_cyc = -1;
    n_done   = 0;
    @(negedge CLK); start4 = 1'b1;
    @(posedge CLK); #1 start4 = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge CLK);
      if (c >= 3 && (c - 3) % 3 == 0 && (c - 3) / 3 < 16) q4 = qv[(c - 3) / 3];
      if (done4 === 1'b1) begin n_done++; if (done_cyc < 0) done_cyc = c; end
      if (c == 51) begin
        tests++; if (sig4 !== exp_sig) begin fails++; $display("FAIL rand_sig: got %h expected %h", sig4, exp_sig); end
        tests++; if (pass4 !== (exp_sig == 16'h0000)) begin fails++; $display("FAIL rand_pass: got %b expected %b", pass4, (exp_sig == 16'h0000)); end
      end
    end
    tests++; if (done_cyc != 51) begin fails++; $display("FAIL rand_done_cycle: got %0d expected 51", done_cyc); end
    tests++; if (n_done != 1) begin fails++; $display("FAIL rand_done_pulses: got %0d expected 1", n_done); end
  endtask

  initial begin
    test_reset();
    test_single_vector(3'b000, 16'hEFDF, 1'b1);
    test_single_vector(3'b111, 16'hEFD8, 1'b0);
    test_two_vectors();
    test_wrap_with_core();
    test_reset_mid_run();
    repeat (3) test_random_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
